fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

- Round-robin write arbiter that shares the single write port of the `FIFO` block among `NUM_REQ` producers.
- Each producer presents data with a valid/ready handshake.
- The arbiter grants one producer at a time for a bounded burst and drives the FIFO's `wr_en`/`data_in` directly.
- It sits between producer blocks and the `intf_fifo` write side, and honours `full` back-pressure.

## Interface
Parameters:
- `NUM_REQ`, 4, number of producers (2..8)
- `DATA_WIDTH`, 16, data word width; must equal the FIFO width
- `MAX_BURST`, 4, maximum accepted writes per grant (1..16)

Ports:
- `clk`  in  1  single clock; all logic on the rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  NUM_REQ  producer i has a word
- `req_data`  in  NUM_REQ*DATA_WIDTH  producer i word at bits [i*DATA_WIDTH +: DATA_WIDTH]
- `req_ready`  out  NUM_REQ  one-hot or zero; producer i word accepted this cycle when valid&ready
- `fifo_full`  in  1  FIFO full flag
- `fifo_overflow`  in  1  FIFO overflow flag
- `fifo_wr_en`  out  1  FIFO write enable
- `fifo_data_in`  out  DATA_WIDTH  FIFO write data
- `grant_id`  out  $clog2(NUM_REQ)  currently granted producer index
- `busy`  out  1  FSM in BURST
- `err_overflow`  out  1  sticky; set when `fifo_overflow` is seen

## Operation
- FSM has two states, IDLE and BURST, held in registers.
  - `grant_id`, `last_grant` and `beat_cnt` (width $clog2(MAX_BURST)+1) are also registered.
- IDLE:
  - If any `req_valid` bit is set, select the first set bit searching from (`last_grant`+1) mod NUM_REQ upward with wrap.
  - Load `grant_id` with it, clear `beat_cnt`, go to BURST.
  - `req_ready` is all-zero in IDLE.
- BURST:
  - `req_ready[grant_id]` = `~fifo_full`; all other bits 0.
  - Accept = `req_valid[grant_id] & req_ready[grant_id]`.
  - On accept: `beat_cnt`+1.
- BURST exit to IDLE (set `last_grant`=`grant_id`) when either:
  - accept with `beat_cnt`==MAX_BURST-1, or
  - `req_valid[grant_id]`==0.
- `fifo_full` in BURST: stay in BURST, `beat_cnt` holds, grant is not revoked.
- Write port:
  - `fifo_wr_en` = accept, combinational; no write without a handshake.
  - `fifo_data_in` = `req_data` slice of `grant_id` (muxed always, including when idle).
- A producer must hold `req_data` stable while `req_valid` is high and not yet accepted.
- `err_overflow` sets on any cycle with `fifo_overflow`=1. It clears only on reset.

## Timing
- Reset (`rst_n`=0 at a clock edge) gives:
  - state IDLE, `grant_id`=0, `last_grant`=NUM_REQ-1, `beat_cnt`=0, `err_overflow`=0;
  - hence `busy`=0, `req_ready`=0 and `fifo_wr_en`=0.
- Reset mid-burst: the next edge forces IDLE. No write occurs in the cycle `rst_n`=0 is sampled, because `req_ready` is gated by `rst_n`.
- Arbitration latency: `req_valid` seen in IDLE at edge N gives BURST from N; first `req_ready` in cycle N→N+1.
- Sustained throughput: MAX_BURST writes per MAX_BURST+1 cycles (one IDLE cycle per grant).
- `fifo_full` is sampled combinationally in the same cycle. A write is never issued while `fifo_full`=1.
- Single requester continuously valid: re-granted after one IDLE cycle (round-robin wraps to itself).
- Requester drops valid in the cycle after its last accept: BURST exits on that cycle with no write.

## Configuration
- `FIFO_ARB_STATS_EN`, when defined:
  - adds input `stat_sel` ($clog2(NUM_REQ)) and output `stat_cnt` (16 bits);
  - keeps one 16-bit saturating (sticks at 16'hFFFF) accepted-write counter per producer, reset to 0;
  - `stat_cnt` is the registered value of counter `stat_sel`, so it has 1-cycle read latency.
- When undefined: these ports and counters do not exist. Behaviour is otherwise identical.

## Test plan
- **Reset, then idle:** `rst_n`=0 for 2 cycles, all `req_valid`=0 → `req_ready`=0, `fifo_wr_en`=0, `busy`=0, `grant_id`=0, `err_overflow`=0.
- **Round-robin, all four requesters:** all four continuously valid, data = 16'hA000+i*16'h100+beat, MAX_BURST=4 → FIFO receives 4 words from req 0, then 1, 2, 3, then 0 again; one idle cycle between groups; 16 writes in 20 cycles.
- **Short burst:** req 2 valid for 2 words only → 2 writes (16'h0201, 16'h0202), BURST exits when valid drops, `last_grant`=2, next grant goes to req 3 if it is valid.
- **Full back-pressure:** force `fifo_full`=1 for 3 cycles mid-burst after beat 1 → `req_ready`=0 and `fifo_wr_en`=0 for those 3 cycles; `grant_id` unchanged; remaining 3 beats complete afterwards.
- **Reset mid-burst:** `rst_n`=0 during beat 2 of req 1 → no write that cycle, IDLE next, and the first grant after release goes to req 0.
- **Overflow flag:** pulse `fifo_overflow` for 1 cycle → `err_overflow`=1 from the next edge and held. With `FIFO_ARB_STATS_EN`: after the round-robin test, `stat_sel`=1 gives `stat_cnt`=16'd4 (or 16'd8 after two rounds).

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin bounded-burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional per-producer accepted-write counters are enabled with FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic                          fifo_overflow,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          err_overflow
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic [$clog2(NUM_REQ)-1:0]    stat_sel,
  output logic [15:0]                   stat_cnt
`endif
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST) + 1;
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_n;
  logic [GW-1:0] last_grant, last_n, grant_n, pick, idx;
  logic [BW-1:0] beat_cnt, beat_n;
  logic [DATA_WIDTH-1:0] words [NUM_REQ];
  logic accept;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign words[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end
  assign busy         = state == BURST;
  assign fifo_data_in = words[grant_id];
  assign req_ready    = (busy && rst_n && !fifo_full) ? NUM_REQ'(1) << grant_id : '0;
  assign accept       = req_valid[grant_id] & req_ready[grant_id];
  assign fifo_wr_en   = accept;
  // Scan downward so the lowest offset from last_grant+1 wins.
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = GW'((int'(last_grant) + i) % NUM_REQ);
      pick = req_valid[idx] ? idx : pick;
    end
  end
  always_comb begin
    state_n = state;
    grant_n = grant_id;
    last_n  = last_grant;
    beat_n  = beat_cnt;
    if (state == IDLE) begin
      if (|req_valid) begin
        state_n = BURST;
        grant_n = pick;
        beat_n  = '0;
      end
    end else begin
      beat_n = accept ? beat_cnt + 1'b1 : beat_cnt;
      if ((accept && beat_cnt == BW'(MAX_BURST - 1)) || !req_valid[grant_id]) begin
        state_n = IDLE;
        last_n  = grant_id;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      grant_id     <= '0;
      last_grant   <= GW'(NUM_REQ - 1);
      beat_cnt     <= '0;
      err_overflow <= 1'b0;
    end else begin
      state        <= state_n;
      grant_id     <= grant_n;
      last_grant   <= last_n;
      beat_cnt     <= beat_n;
      err_overflow <= err_overflow | fifo_overflow;
    end
  end
`ifdef FIFO_ARB_STATS_EN
  logic [15:0] cnt [NUM_REQ];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
      stat_cnt <= '0;
    end else begin
      if (accept && cnt[grant_id] != 16'hFFFF) cnt[grant_id] <= cnt[grant_id] + 16'd1;
      stat_cnt <= cnt[stat_sel];
    end
  end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed stimulus with a write scoreboard checked by an independent monitor.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  typedef struct {int id; logic [15:0] data;} exp_t;
  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] req_valid, req_ready, acc;
  logic [N*DW-1:0] req_data;
  logic fifo_full, fifo_overflow, fifo_wr_en, busy, err_overflow;
  logic [DW-1:0] fifo_data_in;
  logic [1:0] grant_id;
`ifdef FIFO_ARB_STATS_EN
  logic [1:0] stat_sel;
  logic [15:0] stat_cnt;
`endif
  exp_t q[$];
  exp_t e;
  int remain[N], beat[N];
  logic [15:0] base[N];
  int checks = 0, errors = 0, wr_cnt = 0, w0;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_overflow(fifo_overflow),
    .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in), .grant_id(grant_id),
    .busy(busy), .err_overflow(err_overflow)
`ifdef FIFO_ARB_STATS_EN
    , .stat_sel(stat_sel), .stat_cnt(stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    acc <= req_valid & req_ready;
    if (fifo_wr_en) begin
      wr_cnt++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got data %h grant %0d, required no write", fifo_data_in, grant_id);
      end else begin
        e = q.pop_front();
        if (fifo_data_in !== e.data || grant_id !== 2'(e.id)) begin
          errors++;
          $display("FAIL write_data: got data %h grant %0d, required data %h grant %0d",
                   fifo_data_in, grant_id, e.data, e.id);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = remain[i] > 0;
      req_data[i*DW +: DW] = base[i] + 16'(beat[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i]) begin
        remain[i]--;
        beat[i]++;
      end
    drive();
  endtask

  task automatic load(input int i, input int n, input logic [15:0] b);
    remain[i] = n;
    beat[i]   = 0;
    base[i]   = b;
    drive();
  endtask

  task automatic push(input int id, input logic [15:0] d);
    q.push_back('{id, d});
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      remain[i] = 0;
      beat[i]   = 0;
      base[i]   = '0;
    end
    acc = '0;
    rst_n = 1'b0;
    fifo_full = 1'b0;
    fifo_overflow = 1'b0;
`ifdef FIFO_ARB_STATS_EN
    stat_sel = '0;
`endif
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_grant", 32'(grant_id), 32'd0);
    chk("reset_err", 32'(err_overflow), 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 32'd0);
    // Round robin: two rounds of 4-word bursts from every producer.
    for (int i = 0; i < N; i++) load(i, 8, 16'(16'hA000 + i * 16'h100));
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++)
        for (int b = 0; b < 4; b++) push(i, 16'(16'hA000 + i * 16'h100 + r * 4 + b));
    w0 = wr_cnt;
    repeat (20) step();
    chk("rr_writes_in_20_cycles", 32'(wr_cnt - w0), 32'd16);
    repeat (20) step();
    chk("rr_writes_in_40_cycles", 32'(wr_cnt - w0), 32'd32);
`ifdef FIFO_ARB_STATS_EN
    stat_sel = 2'd1;
    step();
    @(negedge clk);
    chk("stat_cnt_req1", 32'(stat_cnt), 32'd8);
`endif
    // Short burst from req 2, then req 3 follows round-robin order.
    load(2, 2, 16'h0201);
    load(3, 1, 16'h0301);
    push(2, 16'h0201);
    push(2, 16'h0202);
    push(3, 16'h0301);
    repeat (10) step();
    chk("short_idle_after", 32'(busy), 32'd0);
    // Back-pressure for 3 cycles after the first beat of req 0.
    load(0, 4, 16'hB000);
    for (int b = 0; b < 4; b++) push(0, 16'(16'hB000 + b));
    step();
    step();
    fifo_full = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_ready", 32'(req_ready), 32'd0);
      chk("full_wr_en", 32'(fifo_wr_en), 32'd0);
      chk("full_grant", 32'(grant_id), 32'd0);
      chk("full_busy", 32'(busy), 32'd1);
      step();
    end
    fifo_full = 1'b0;
    repeat (6) step();
    // Reset during the second beat of req 1.
    load(1, 4, 16'hC000);
    push(1, 16'hC000);
    step();
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd0);
    step();
    rst_n = 1'b1;
    load(0, 1, 16'hD000);
    @(negedge clk);
    chk("rst_mid_idle", 32'(busy), 32'd0);
    push(0, 16'hD000);
    push(1, 16'hC001);
    push(1, 16'hC002);
    push(1, 16'hC003);
    repeat (12) step();
    // Overflow flag is sticky from the next edge.
    fifo_overflow = 1'b1;
    @(negedge clk);
    chk("ovf_before_edge", 32'(err_overflow), 32'd0);
    step();
    fifo_overflow = 1'b0;
    @(negedge clk);
    chk("ovf_set", 32'(err_overflow), 32'd1);
    repeat (3) step();
    @(negedge clk);
    chk("ovf_held", 32'(err_overflow), 32'd1);
    repeat (3) step();
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
